// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes, complex sample type and twiddle table for the 32-point FFT
//
// Purpose : common definitions for the in-place radix-2 DIT FFT scheduler.
//           A complex sample is packed {real, imag}, each a Q1.15 two's-complement word.
// Contents: N_POINTS / LOG2N / DW sizes, cplx_t, FSM state type, TWIDDLE_ROM,
//           and cplx_asr1 (per-component halving used by the stage-scaling build).
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int LOG2N    = 5;
  localparam int DW       = 16;

  // Butterflies per stage, and the width of the twiddle index k (0..15).
  localparam int N_BFLY = N_POINTS / 2;
  localparam int KW     = LOG2N - 1;
  // Stage counter width (stages 0..4).
  localparam int SW     = 3;

  localparam logic [KW-1:0] J_LAST = KW'(N_BFLY - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fsm_state_t;

  // W^k = cos(2*pi*k/32) - j*sin(2*pi*k/32), rounded to Q1.15; cos(0) saturates to 0x7FFF.
  localparam cplx_t TWIDDLE_ROM [N_BFLY] = '{
    32'h7FFF_0000, 32'h7D8A_E707, 32'h7642_CF04, 32'h6A6E_B8E3,
    32'h5A82_A57E, 32'h471D_9592, 32'h30FC_89BE, 32'h18F9_8276,
    32'h0000_8000, 32'hE707_8276, 32'hCF04_89BE, 32'hB8E3_9592,
    32'hA57E_A57E, 32'h9592_B8E3, 32'h89BE_CF04, 32'h8276_E707
  };

  // Arithmetic shift right by one on both components (truncates toward -inf).
  function automatic cplx_t cplx_asr1(input cplx_t x);
    cplx_t r;
    r.re = x.re >>> 1;
    r.im = x.im >>> 1;
    return r;
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// rtl/fft_twiddle_rom.sv - registered twiddle lookup with one cycle of latency
//
// Purpose : turns the twiddle index issued alongside the read addresses into W,
//           arriving in the same cycle as the RAM read data.
// Ports   : clk, rst_n  - clock, asynchronous active-low reset
//           en          - capture a new entry (high while reads are issued)
//           k           - twiddle index 0..15
//           w           - registered W^k; holds its value while en is low
module fft_twiddle_rom
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [KW-1:0] k,
  output cplx_t         w
);

  cplx_t w_q;
  cplx_t w_d;

  always_comb begin
    w_d = w_q;
    if (en) begin
      w_d = TWIDDLE_ROM[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign w = w_q;

endmodule

// File: rtl/fft32_bfly_scheduler.sv
// rtl/fft32_bfly_scheduler.sv - butterfly scheduler for an in-place 32-point radix-2 DIT FFT
//
// Purpose : walks 5 stages x 16 butterflies over a dual-port sample RAM (input
//           already in bit-reversed order), feeding an external combinational
//           butterfly unit and writing its results back to the operand addresses.
// Pipeline: P0 issue read addresses + twiddle index, P1 RAM data/W presented to the
//           butterfly, P2 results registered with wr_en. A read in cycle t is
//           written in cycle t+2; two DRAIN cycles per stage keep stage s+1 reads
//           behind stage s writes.
// Ports   : clk, rst_n            - clock, asynchronous active-low reset
//           start                 - begin an FFT (only honoured in IDLE)
//           busy, done            - run in progress / one-cycle completion pulse
//           rd_en, rd_addr_a/b    - RAM read strobe and operand addresses
//           rd_data_a/b           - RAM read data, valid one cycle after rd_en
//           bf_a, bf_b, bf_w      - operands and twiddle to the butterfly unit
//           bf_a_f, bf_b_f        - butterfly results (combinational)
//           wr_en, wr_addr_a/b,
//           wr_data_a/b           - write-back to both RAM ports
// Macro   : FFT_STAGE_SCALE_EN - halve every result component before write-back
//           (1/32 overall) so no Q1.15 input can overflow.
module fft32_bfly_scheduler
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [LOG2N-1:0]  rd_addr_a,
  output logic [LOG2N-1:0]  rd_addr_b,
  input  logic [2*DW-1:0]   rd_data_a,
  input  logic [2*DW-1:0]   rd_data_b,
  output logic [2*DW-1:0]   bf_a,
  output logic [2*DW-1:0]   bf_b,
  output logic [2*DW-1:0]   bf_w,
  input  logic [2*DW-1:0]   bf_a_f,
  input  logic [2*DW-1:0]   bf_b_f,
  output logic              wr_en,
  output logic [LOG2N-1:0]  wr_addr_a,
  output logic [LOG2N-1:0]  wr_addr_b,
  output logic [2*DW-1:0]   wr_data_a,
  output logic [2*DW-1:0]   wr_data_b
);

  localparam logic [LOG2N-1:0] ONE_A = LOG2N'(1);

  // Control state
  fsm_state_t       state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [KW-1:0]    j_q, j_d;
  logic             drain_q, drain_d;

  // P0 registered outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0]    k_q, k_d;

  // P1 tracking and operand hold
  logic             p1_valid_q, p1_valid_d;
  logic [LOG2N-1:0] p1_addr_a_q, p1_addr_a_d;
  logic [LOG2N-1:0] p1_addr_b_q, p1_addr_b_d;
  logic [2*DW-1:0]  hold_a_q, hold_a_d;
  logic [2*DW-1:0]  hold_b_q, hold_b_d;

  // P2 write-back
  logic             wr_en_q, wr_en_d;
  logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [LOG2N-1:0] wr_addr_b_q, wr_addr_b_d;
  logic [2*DW-1:0]  wr_data_a_q, wr_data_a_d;
  logic [2*DW-1:0]  wr_data_b_q, wr_data_b_d;

  // Address generation scratch
  logic [LOG2N-1:0] pos_mask;
  logic [LOG2N-1:0] j_ext;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;

  cplx_t            res_a;
  cplx_t            res_b;
  cplx_t            rom_w;

  fft_twiddle_rom u_twiddle_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en_q),
    .k     (k_q),
    .w     (rom_w)
  );

  // P1: operands come straight from RAM while valid, otherwise the last pair is held.
  assign bf_a = p1_valid_q ? rd_data_a : hold_a_q;
  assign bf_b = p1_valid_q ? rd_data_b : hold_b_q;
  assign bf_w = rom_w;

  always_comb begin
`ifdef FFT_STAGE_SCALE_EN
    res_a = cplx_asr1(cplx_t'(bf_a_f));
    res_b = cplx_asr1(cplx_t'(bf_b_f));
`else
    res_a = cplx_t'(bf_a_f);
    res_b = cplx_t'(bf_b_f);
`endif
  end

  // Sequencing: IDLE -> (ISSUE x16 -> DRAIN x2) per stage -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          s_d     = '0;
          j_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            s_d     = s_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pair addresses for the (s, j) about to be issued. Splitting j at bit s and
  // inserting a zero there gives grp*2h + pos; setting that bit gives the B partner.
  always_comb begin
    pos_mask = (ONE_A << s_d) - ONE_A;
    j_ext    = {1'b0, j_d};
    pos      = j_ext & pos_mask;
    addr_a   = ((j_ext & ~pos_mask) << 1) | pos;
    addr_b   = addr_a | (ONE_A << s_d);
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    rd_en_d     = (state_d == ST_ISSUE);
    rd_addr_a_d = rd_en_d ? addr_a : '0;
    rd_addr_b_d = rd_en_d ? addr_b : '0;
    // pos < 2^s, so pos << (4-s) always fits in 4 bits.
    k_d         = rd_en_d ? KW'(pos << (S_LAST - s_d)) : '0;

    p1_valid_d  = rd_en_q;
    p1_addr_a_d = rd_en_q ? rd_addr_a_q : p1_addr_a_q;
    p1_addr_b_d = rd_en_q ? rd_addr_b_q : p1_addr_b_q;
    hold_a_d    = bf_a;
    hold_b_d    = bf_b;

    wr_en_d     = p1_valid_q;
    wr_addr_a_d = p1_valid_q ? p1_addr_a_q : wr_addr_a_q;
    wr_addr_b_d = p1_valid_q ? p1_addr_b_q : wr_addr_b_q;
    wr_data_a_d = p1_valid_q ? res_a : wr_data_a_q;
    wr_data_b_d = p1_valid_q ? res_b : wr_data_b_q;
  end

  // Asynchronous reset aborts a run at once: wr_en falls without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      j_q         <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      k_q         <= '0;
      p1_valid_q  <= 1'b0;
      p1_addr_a_q <= '0;
      p1_addr_b_q <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
      wr_data_a_q <= '0;
      wr_data_b_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      j_q         <= j_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      k_q         <= k_d;
      p1_valid_q  <= p1_valid_d;
      p1_addr_a_q <= p1_addr_a_d;
      p1_addr_b_q <= p1_addr_b_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      wr_en_q     <= wr_en_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
      wr_data_a_q <= wr_data_a_d;
      wr_data_b_q <= wr_data_b_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign wr_en     = wr_en_q;
  assign wr_addr_a = wr_addr_a_q;
  assign wr_addr_b = wr_addr_b_q;
  assign wr_data_a = wr_data_a_q;
  assign wr_data_b = wr_data_b_q;

endmodule

// File: tb/tb_fft32_bfly_scheduler.sv
// tb/tb_fft32_bfly_scheduler.sv - directed self-checking bench for fft32_bfly_scheduler
module tb_fft32_bfly_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] bf_a;
  logic [31:0] bf_b;
  logic [31:0] bf_w;
  logic [31:0] bf_a_f;
  logic [31:0] bf_b_f;
  logic        wr_en;
  logic [4:0]  wr_addr_a;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_a;
  logic [31:0] wr_data_b;

  int total = 0;
  int bad   = 0;

  fft32_bfly_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .bf_a      (bf_a),
    .bf_b      (bf_b),
    .bf_w      (bf_w),
    .bf_a_f    (bf_a_f),
    .bf_b_f    (bf_b_f),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Butterfly unit: A + W*B, A - W*B with the Q1.15 product rounded.
  function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w, input bit sub);
    longint ar, ai, br, bi, wr, wi, tr, ti;
    ar = longint'(signed'(a[31:16]));
    ai = longint'(signed'(a[15:0]));
    br = longint'(signed'(b[31:16]));
    bi = longint'(signed'(b[15:0]));
    wr = longint'(signed'(w[31:16]));
    wi = longint'(signed'(w[15:0]));
    tr = (br * wr - bi * wi + 64'sd16384) >>> 15;
    ti = (br * wi + bi * wr + 64'sd16384) >>> 15;
    if (sub) return {16'(ar - tr), 16'(ai - ti)};
    return {16'(ar + tr), 16'(ai + ti)};
  endfunction

  assign bf_a_f = bfly(bf_a, bf_b, bf_w, 1'b0);
  assign bf_b_f = bfly(bf_a, bf_b, bf_w, 1'b1);

  // Dual-port sample RAM with registered reads and a one-shot bulk load.
  logic [31:0] ram [0:31];
  logic [31:0] img [0:31];
  logic        ld_req;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
    end
    if (ld_req) begin
      for (int i = 0; i < 32; i++) ram[i] <= img[i];
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  // Per-run observations, indexed by cycle after the start pulse.
  int          busy_cnt, busy_first, busy_last, done_cnt, done_cyc;
  int          rd_cnt, wr_cnt, drain_rd, lag_err;
  logic [4:0]  tra [0:127];
  logic [4:0]  trb [0:127];
  logic [31:0] trw [0:127];
  logic [31:0] tba [0:127];
  logic [31:0] tbb [0:127];
  logic        trv [0:127];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Start pulse in cycle 0, then observe cycles 1..120 (bounded). With poke set,
  // start is re-pulsed in cycle 30 (busy) and cycle 91 (DONE).
  task automatic run_fft(input bit poke);
    logic prev_rd;
    busy_cnt = 0; busy_first = -1; busy_last = -1; done_cnt = 0; done_cyc = -1;
    rd_cnt = 0; wr_cnt = 0; drain_rd = 0; lag_err = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      start = (poke && (c == 30 || c == 91));
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (rd_en) begin
        rd_cnt++;
        if (((c - 1) % 18) >= 16) drain_rd++;
      end
      if (wr_en) wr_cnt++;
      prev_rd = (c >= 3) ? trv[c-2] : 1'b0;
      if (wr_en !== prev_rd) lag_err++;
      else if (wr_en && (wr_addr_a !== tra[c-2] || wr_addr_b !== trb[c-2])) lag_err++;
      tra[c] = rd_addr_a;
      trb[c] = rd_addr_b;
      trv[c] = rd_en;
      trw[c] = bf_w;
      tba[c] = bf_a;
      tbb[c] = bf_b;
    end
    start = 1'b0;
  endtask

`ifdef FFT_STAGE_SCALE_EN
  localparam logic [31:0] IMP_BIN = 32'h001F_0000;
  localparam logic [31:0] DC_BIN0 = 32'h03E8_0000;
`else
  localparam logic [31:0] IMP_BIN = 32'h03FF_0000;
  localparam logic [31:0] DC_BIN0 = 32'h7D00_0000;
`endif

  int wr_after;
  int re_v, im_v;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    ld_req = 1'b0;
    for (int i = 0; i < 32; i++) img[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_bf_w", bf_w, 0);
    chk("rst_bf_a", bf_a, 0);
    rst_n = 1'b1;

    // Impulse at index 0: timing, address/twiddle trace, spectrum
    img[0] = 32'h03FF_0000;
    load_img();
    run_fft(1'b0);
    chk("busy_cycles", busy_cnt, 90);
    chk("busy_first", busy_first, 1);
    chk("busy_last", busy_last, 90);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc, 91);
    chk("rd_count", rd_cnt, 80);
    chk("wr_count", wr_cnt, 80);
    chk("rd_in_drain", drain_rd, 0);
    chk("wr_lag2", lag_err, 0);
    chk("s0j0_a", tra[1], 0);
    chk("s0j0_b", trb[1], 1);
    chk("s0j1_a", tra[2], 2);
    chk("s0j1_b", trb[2], 3);
    chk("s0j2_a", tra[3], 4);
    chk("s0j2_b", trb[3], 5);
    chk("s0j0_w", trw[2], 32'h7FFF_0000);
    chk("s0j1_w", trw[3], 32'h7FFF_0000);
    chk("s0j2_w", trw[4], 32'h7FFF_0000);
    chk("s2j5_a", tra[42], 9);
    chk("s2j5_b", trb[42], 13);
    chk("s2j5_w", trw[43], 32'h5A82_A57E);
    chk("s4j15_a", tra[88], 15);
    chk("s4j15_b", trb[88], 31);
    chk("s4j15_w", trw[89], 32'h8276_E707);
    for (int i = 0; i < 32; i++) chk($sformatf("imp_bin%0d", i), ram[i], IMP_BIN);

    // DC input with stray start pulses during busy and DONE
    for (int i = 0; i < 32; i++) img[i] = 32'h03E8_0000;
    load_img();
    run_fft(1'b1);
    chk("poke_done_count", done_cnt, 1);
    chk("poke_done_cycle", done_cyc, 91);
    chk("poke_busy_cycles", busy_cnt, 90);
    chk("poke_busy_last", busy_last, 90);
    chk("poke_rd_count", rd_cnt, 80);
    chk("dc_bf_a_hold", tba[18], 32'h03E8_0000);
    chk("dc_bf_b_hold", tbb[18], 32'h03E8_0000);
    chk("dc_bin0", ram[0], DC_BIN0);
    for (int i = 1; i < 32; i++) begin
      re_v = int'(signed'(ram[i][31:16]));
      im_v = int'(signed'(ram[i][15:0]));
      chk($sformatf("dc_bin%0d_small", i),
          (re_v >= -2 && re_v <= 2 && im_v >= -2 && im_v <= 2), 1);
    end

    // Reset during stage 2, j=7
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_abort_wr_en", wr_en, 1);
    chk("pre_abort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bf_a", bf_a, 0);
    chk("abort_bf_w", bf_w, 0);
    chk("abort_wr_data", wr_data_a, 0);
    wr_after = 0;
    repeat (4) begin
      @(negedge clk);
      if (wr_en !== 1'b0) wr_after++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0) wr_after++;
    end
    chk("abort_no_writes", wr_after, 0);

    // Reload and run normally after the abort
    for (int i = 0; i < 32; i++) img[i] = 32'h0;
    img[0] = 32'h03FF_0000;
    load_img();
    run_fft(1'b0);
    chk("rerun_busy_cycles", busy_cnt, 90);
    chk("rerun_done_cycle", done_cyc, 91);
    chk("rerun_wr_count", wr_cnt, 80);
    chk("rerun_bin0", ram[0], IMP_BIN);
    chk("rerun_bin17", ram[17], IMP_BIN);
    chk("rerun_bin31", ram[31], IMP_BIN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
